vdp_super_res_writer: RTL and testbench
=======================================

// Module: vdp_super_res_writer
// PURPOSE
//  CPU-side writer for the super-res/super-mid linear framebuffer: takes a byte stream
//  from the VDP port logic, packs it into 32-bit VRAM words with byte enables, queues
//  them and issues VRAM writes only while the display scan does not own the bus.
//  Sits between the port decoder and the VRAM address/data mux.
// PARAMETERS
//  FIFO_DEPTH   4        pending word writes (power of 2, >=2)
//  PIXEL_LIMIT  414720   byte count of framebuffer (720x576); pointer wraps here
// PORTS
//  clk               in   1   system clock
//  reset_n           in   1   async reset, active low
//  vdp_super         in   1   super mode enable; low = synchronous clear of all state
//  super_res_drawing in   1   1 = display owns VRAM bus this cycle
//  cpu_addr_wr       in   1   load byte pointer from cpu_addr (1-cycle strobe)
//  cpu_addr          in   19  byte address
//  cpu_data_wr       in   1   write cpu_data at pointer, then pointer+1 (1-cycle strobe)
//  cpu_data          in   8   pixel palette index
//  cpu_flush         in   1   force partial word into FIFO
//  cpu_ready         out  1   1 = a cpu_data_wr will be accepted
//  overrun           out  1   sticky: write dropped while cpu_ready=0; cleared by cpu_addr_wr
//  vram_wr_req       out  1   write request
//  vram_wr_addr      out  17  word address
//  vram_wr_data      out  32  data, byte n = bits [8n+7:8n]
//  vram_wr_be        out  4   byte enables
//  vram_wr_ack       in   1   arbiter completed write (1 cycle)
// BEHAVIOUR
//  Reset/clear: pointer=0, accumulator mask=0, FIFO empty, state IDLE, all outputs 0
//   except cpu_ready=1. Reset mid-request drops vram_wr_req immediately; no retry.
//  Accumulator: word addr = pointer[18:2]; byte lane = pointer[1:0]; mask bit set per write.
//  Flush to FIFO (entry {addr,data,be}) when any of, evaluated after the current write:
//   - lane 3 written; - pointer's word changes (cpu_addr_wr to other word, or wrap);
//   - cpu_flush with mask!=0. Flush with mask==0 is a no-op.
//  Pointer increment: PIXEL_LIMIT-1 -> 0 (flush occurs, new word 0).
//  Same-cycle cpu_data_wr + cpu_addr_wr: byte goes to old pointer, then pointer loaded.
//  Same-cycle cpu_data_wr + cpu_flush: byte merged, then word flushed.
//  Rewrite of an already-set lane overwrites data; mask unchanged.
//  cpu_ready = !(FIFO full && a flush could be required): drop to 0 when FIFO has
//   FIFO_DEPTH entries. Write with cpu_ready=0: ignored, overrun<=1, pointer unchanged.
//  Latency: lane-3 write in cycle N -> FIFO entry valid N+1 -> vram_wr_req earliest N+2.
//  FSM: IDLE -> (FIFO !empty && !super_res_drawing) -> REQ; REQ holds req/addr/data/be
//   stable until vram_wr_ack; on ack pop FIFO, -> IDLE (back-to-back allowed: same cycle
//   re-evaluate, -> REQ if next entry and window open). req never rises while
//   super_res_drawing=1; once raised it is held even if drawing rises (arbiter completes).
//  FIFO simultaneous push+pop when full is legal; level unchanged.
//  vdp_super low mid-operation: same as reset (pending words discarded).
// STRUCTURE
//  Package vdp_super_pkg: SUPER_RES_PIXELS constant, vram_word_t {addr[16:0],data[31:0],
//   be[3:0]}, writer_state_e {IDLE,REQ}.
//  Sub-module vdp_wr_fifo: sync FIFO of vram_word_t, push/pop/full/empty/level.
// TESTING
//  1 ptr=0x100, write 0x11,0x22,0x33,0x44, drawing=0 -> one req addr=0x40,
//    data=0x44332211, be=4'hF, 2 cycles after 4th byte.
//  2 ptr=0x102, write 0xAA, flush -> addr=0x40, data[23:16]=0xAA, be=4'b0100.
//  3 hold drawing=1, write 20 bytes -> req stays 0, cpu_ready falls after 4 words,
//    5th-word write sets overrun; drop drawing -> 4 writes in order, ack each.
//  4 ptr=414718, write 3 bytes -> word 103679 be=4'b1100, then pointer 0, lane 0 set.
//  5 drawing rises while req=1 -> req held until ack; no new req until drawing=0.
//  6 reset_n low while req=1 -> req 0 same cycle, FIFO empty, cpu_ready=1 after release.

Source files
------------

// File: rtl/vdp_super_pkg.sv
// Shared types and constants for the super-res framebuffer write path.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package vdp_super_pkg;

  // Byte count of the 720x576 linear framebuffer.
  localparam int SUPER_RES_PIXELS = 414720;
  localparam int BYTE_ADDR_W      = 19;
  localparam int WORD_ADDR_W      = 17;

  // One pending VRAM write: word address, little-endian data, byte enables.
  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [3:0]             be;
  } vram_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } writer_state_e;

  // Replace byte lane 'lane' of 'word' with 'b'.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/vdp_wr_fifo.sv
// Synchronous FIFO of pending VRAM word writes with a synchronous clear.
// Latency: a pushed entry is visible on pop_data the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module vdp_wr_fifo
  import vdp_super_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  vram_word_t               push_data,
  input  logic                     pop,
  output vram_word_t               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  vram_word_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign do_pop   = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vdp_super_res_writer.sv
// Packs CPU bytes into 32-bit VRAM words and writes them while the display scan is off the bus.
// Latency: lane-3 byte in cycle N -> FIFO entry N+1 -> vram_wr_req at the earliest in N+2.
// Backpressure: cpu_ready drops while the word FIFO is full; writes then are dropped and flag overrun.
module vdp_super_res_writer
  import vdp_super_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int PIXEL_LIMIT = SUPER_RES_PIXELS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vdp_super,
  input  logic                   super_res_drawing,
  input  logic                   cpu_addr_wr,
  input  logic [BYTE_ADDR_W-1:0] cpu_addr,
  input  logic                   cpu_data_wr,
  input  logic [7:0]             cpu_data,
  input  logic                   cpu_flush,
  output logic                   cpu_ready,
  output logic                   overrun,
  output logic                   vram_wr_req,
  output logic [WORD_ADDR_W-1:0] vram_wr_addr,
  output logic [31:0]            vram_wr_data,
  output logic [3:0]             vram_wr_be,
  input  logic                   vram_wr_ack
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Accumulator and pointer state.
  logic [BYTE_ADDR_W-1:0] ptr_q;
  logic [31:0]            acc_data_q;
  logic [3:0]             acc_be_q;
  logic                   overrun_q;

  // Combinational next values.
  logic                   wr_ok;
  logic [1:0]             lane;
  logic [3:0]             be_after;
  logic [31:0]            data_after;
  logic [BYTE_ADDR_W-1:0] ptr_inc;
  logic [BYTE_ADDR_W-1:0] ptr_next;
  logic                   word_change;
  logic                   flush_req;
  vram_word_t             push_entry;

  // FIFO and FSM.
  writer_state_e          state_q;
  writer_state_e          state_d;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LW-1:0]          fifo_level;
  vram_word_t             fifo_head;

  // With the FIFO full the accumulator is always empty (every push clears it),
  // so blocking data writes alone is enough to never lose a flush.
  assign cpu_ready = !fifo_full;
  assign overrun   = overrun_q;

  // Merge the incoming byte, advance/load the pointer and decide whether the word leaves.
  always_comb begin
    lane        = ptr_q[1:0];
    wr_ok       = cpu_data_wr && cpu_ready;
    be_after    = acc_be_q;
    data_after  = acc_data_q;
    if (wr_ok) begin
      be_after   = acc_be_q | (4'b0001 << lane);
      data_after = merge_byte(acc_data_q, lane, cpu_data);
    end
    ptr_inc     = (ptr_q == BYTE_ADDR_W'(PIXEL_LIMIT - 1)) ? '0 : ptr_q + BYTE_ADDR_W'(1);
    ptr_next    = ptr_q;
    if (cpu_addr_wr) begin
      ptr_next = cpu_addr;
    end else if (wr_ok) begin
      ptr_next = ptr_inc;
    end
    word_change = (ptr_next[BYTE_ADDR_W-1:2] != ptr_q[BYTE_ADDR_W-1:2]);
    flush_req   = (be_after != 4'b0000) &&
                  ((wr_ok && (lane == 2'd3)) || word_change || cpu_flush);
    push_entry  = '{addr: ptr_q[BYTE_ADDR_W-1:2], data: data_after, be: be_after};
    fifo_push   = vdp_super && flush_req;
  end

  // Pointer, accumulator and sticky overrun; vdp_super low clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      acc_data_q <= '0;
      acc_be_q   <= '0;
      overrun_q  <= 1'b0;
    end else if (!vdp_super) begin
      ptr_q      <= '0;
      acc_data_q <= '0;
      acc_be_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      ptr_q <= ptr_next;
      if (flush_req) begin
        acc_data_q <= '0;
        acc_be_q   <= '0;
      end else begin
        acc_data_q <= data_after;
        acc_be_q   <= be_after;
      end
      // The dropped byte is logically before the pointer load, so a load clears it.
      if (cpu_addr_wr) begin
        overrun_q <= 1'b0;
      end else if (cpu_data_wr && !cpu_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  vdp_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (!vdp_super),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Request state register; async reset drops the request immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: raise only outside the scan window, hold until ack, chain back-to-back.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !super_res_drawing) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (vram_wr_ack) begin
          fifo_pop = 1'b1;
          if (((fifo_level > LW'(1)) || fifo_push) && !super_res_drawing) begin
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!vdp_super) begin
      state_d  = IDLE;
      fifo_pop = 1'b0;
    end
  end

  // Present the FIFO head only while requesting; outputs idle at zero.
  always_comb begin
    vram_wr_req  = (state_q == REQ);
    vram_wr_addr = '0;
    vram_wr_data = '0;
    vram_wr_be   = '0;
    if (state_q == REQ) begin
      vram_wr_addr = fifo_head.addr;
      vram_wr_data = fifo_head.data;
      vram_wr_be   = fifo_head.be;
    end
  end

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// Self-checking bench for vdp_super_res_writer: table of write/flush vectors plus corner sequences.
// Expected VRAM words are queued when stimulus is driven and compared when the bench acks.
// Inputs change #1 after the rising edge; outputs are observed at the falling edge.
module tb_vdp_super_res_writer;
  import vdp_super_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vdp_super;
  logic        drawing;
  logic        cpu_addr_wr;
  logic [18:0] cpu_addr;
  logic        cpu_data_wr;
  logic [7:0]  cpu_data;
  logic        cpu_flush;
  logic        cpu_ready;
  logic        overrun;
  logic        vram_wr_req;
  logic [16:0] vram_wr_addr;
  logic [31:0] vram_wr_data;
  logic [3:0]  vram_wr_be;
  logic        ack = 1'b0;

  int checks = 0;
  int errors = 0;

  vram_word_t sb[$];
  bit         auto_ack = 1'b1;
  int         ack_lat  = 1;

  always #5 clk = ~clk;

  vdp_super_res_writer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .vdp_super         (vdp_super),
    .super_res_drawing (drawing),
    .cpu_addr_wr       (cpu_addr_wr),
    .cpu_addr          (cpu_addr),
    .cpu_data_wr       (cpu_data_wr),
    .cpu_data          (cpu_data),
    .cpu_flush         (cpu_flush),
    .cpu_ready         (cpu_ready),
    .overrun           (overrun),
    .vram_wr_req       (vram_wr_req),
    .vram_wr_addr      (vram_wr_addr),
    .vram_wr_data      (vram_wr_data),
    .vram_wr_be        (vram_wr_be),
    .vram_wr_ack       (ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Arbiter model and bus monitor: protocol checks, ack generation, scoreboard compare.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_draw = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_be = '0;
    int          ack_cnt = 0;
    vram_word_t  e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (vram_wr_req && !prev_req) chk("req_rise_during_drawing", prev_draw, 1'b0);
        if (vram_wr_req && prev_req && !ack) begin
          chk("hold_addr", vram_wr_addr, prev_addr);
          chk("hold_data", vram_wr_data, prev_data);
          chk("hold_be", vram_wr_be, prev_be);
        end
      end
      if (ack) begin
        ack = 1'b0;
      end else if (auto_ack && vram_wr_req) begin
        if (ack_cnt >= ack_lat) begin
          chk("write_expected", (sb.size() > 0), 1'b1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("wr_addr", vram_wr_addr, e.addr);
            chk("wr_be", vram_wr_be, e.be);
            chk("wr_data", vram_wr_data & be_mask(e.be), e.data & be_mask(e.be));
          end
          ack = 1'b1;
          ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end
      prev_req  = vram_wr_req;
      prev_draw = drawing;
      prev_addr = vram_wr_addr;
      prev_data = vram_wr_data;
      prev_be   = vram_wr_be;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input logic [18:0] a);
    cpu_addr = a; cpu_addr_wr = 1'b1; tick(); cpu_addr_wr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b);
    cpu_data = b; cpu_data_wr = 1'b1; tick(); cpu_data_wr = 1'b0;
  endtask

  task automatic do_flush();
    cpu_flush = 1'b1; tick(); cpu_flush = 1'b0;
  endtask

  task automatic expect_word(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    sb.push_back('{addr: a, data: d, be: be});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || vram_wr_req) && n < 300) begin tick(); n++; end
    chk({name, "_drain"}, (n < 300), 1'b1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!vram_wr_req && n < 50) begin tick(); n++; end
    chk({name, "_req_seen"}, vram_wr_req, 1'b1);
  endtask

  typedef struct {
    logic [18:0]      ptr;
    int               n;
    logic [3:0][7:0]  bytes;
    int               mode;   // 0 none, 1 cpu_flush, 2 pointer load to another word
    vram_word_t       exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{19'h00100, 4, {8'h44, 8'h33, 8'h22, 8'h11}, 0, '{17'h00040, 32'h44332211, 4'hF}};
    vt[1] = '{19'h00102, 1, {8'h00, 8'h00, 8'h00, 8'hAA}, 1, '{17'h00040, 32'h00AA0000, 4'b0100}};
    vt[2] = '{19'h00201, 2, {8'h00, 8'h00, 8'hA5, 8'h5A}, 1, '{17'h00080, 32'h00A55A00, 4'b0110}};
    vt[3] = '{19'h00003, 1, {8'h00, 8'h00, 8'h00, 8'h77}, 0, '{17'h00000, 32'h77000000, 4'b1000}};
    vt[4] = '{19'h048D1, 3, {8'h00, 8'h03, 8'h02, 8'h01}, 0, '{17'h01234, 32'h03020100, 4'b1110}};
    vt[5] = '{19'h00010, 2, {8'h00, 8'h00, 8'hC2, 8'hC1}, 2, '{17'h00004, 32'h0000C2C1, 4'b0011}};
    vt[6] = '{19'h00043, 1, {8'h00, 8'h00, 8'h00, 8'h9E}, 1, '{17'h00010, 32'h9E000000, 4'b1000}};

    reset_n = 1'b0; vdp_super = 1'b1; drawing = 1'b0;
    cpu_addr_wr = 1'b0; cpu_addr = '0; cpu_data_wr = 1'b0; cpu_data = '0; cpu_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", vram_wr_req, 1'b0);
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_addr", vram_wr_addr, 17'h0);
    chk("rst_data", vram_wr_data, 32'h0);
    chk("rst_be", vram_wr_be, 4'h0);
    reset_n = 1'b1;
    tick();

    // Table of single-word packing cases.
    for (int i = 0; i < 7; i++) begin
      expect_word(vt[i].exp.addr, vt[i].exp.data, vt[i].exp.be);
      set_ptr(vt[i].ptr);
      for (int j = 0; j < vt[i].n; j++) wr(vt[i].bytes[j]);
      if (vt[i].mode == 1) do_flush();
      if (vt[i].mode == 2) set_ptr(19'h07000);
      wait_drain($sformatf("vec%0d", i));
    end

    // Flush with an empty accumulator produces nothing.
    do_flush();
    repeat (4) tick();
    chk("empty_flush_no_req", vram_wr_req, 1'b0);

    // Lane-3 write to request latency is two cycles.
    auto_ack = 1'b0;
    set_ptr(19'h00100);
    wr(8'h11); wr(8'h22); wr(8'h33);
    expect_word(17'h00040, 32'h44332211, 4'hF);
    cpu_data = 8'h44; cpu_data_wr = 1'b1;
    @(negedge clk);
    chk("lat_cycle_n", vram_wr_req, 1'b0);
    tick(); cpu_data_wr = 1'b0;
    @(negedge clk);
    chk("lat_cycle_n1", vram_wr_req, 1'b0);
    tick();
    chk("lat_cycle_n2", vram_wr_req, 1'b1);
    auto_ack = 1'b1;
    wait_drain("lat");

    // Rewriting a lane overwrites data; same-cycle data+load and data+flush.
    expect_word(17'h00008, 32'h000000E2, 4'b0001);
    set_ptr(19'h00020); wr(8'hE1); set_ptr(19'h00020); wr(8'hE2); do_flush();
    wait_drain("rewrite");
    expect_word(17'h0000C, 32'h000000F1, 4'b0001);
    expect_word(17'h00010, 32'h000000F2, 4'b0001);
    set_ptr(19'h00030);
    cpu_data = 8'hF1; cpu_data_wr = 1'b1; cpu_addr = 19'h00040; cpu_addr_wr = 1'b1;
    tick(); cpu_data_wr = 1'b0; cpu_addr_wr = 1'b0;
    wr(8'hF2); do_flush();
    wait_drain("data_and_load");
    expect_word(17'h00014, 32'h0000F300, 4'b0010);
    set_ptr(19'h00051);
    cpu_data = 8'hF3; cpu_data_wr = 1'b1; cpu_flush = 1'b1;
    tick(); cpu_data_wr = 1'b0; cpu_flush = 1'b0;
    wait_drain("data_and_flush");

    // Scan owns the bus: FIFO fills, ready falls, overrun, then in-order drain.
    drawing = 1'b1;
    set_ptr(19'h00000);
    for (int w = 0; w < 4; w++)
      expect_word(17'(w), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)}, 4'hF);
    for (int k = 0; k < 20; k++) begin
      cpu_data = 8'(k + 1); cpu_data_wr = 1'b1;
      @(negedge clk);
      chk($sformatf("full_ready_%0d", k), cpu_ready, (k < 16));
      if (k == 16) chk("overrun_before_drop", overrun, 1'b0);
      tick();
    end
    cpu_data_wr = 1'b0;
    repeat (3) tick();
    chk("full_no_req_while_drawing", vram_wr_req, 1'b0);
    chk("overrun_set", overrun, 1'b1);
    ack_lat = 0;
    drawing = 1'b0;
    wait_drain("full");
    chk("ready_after_drain", cpu_ready, 1'b1);
    chk("overrun_sticky", overrun, 1'b1);
    expect_word(17'h00004, 32'h000000BB, 4'b0001);
    wr(8'hBB); do_flush();
    wait_drain("ptr_held");
    set_ptr(19'h00300);
    chk("overrun_cleared", overrun, 1'b0);

    // Wrap at the end of the framebuffer.
    expect_word(17'd103679, 32'hB1B00000, 4'b1100);
    expect_word(17'h00000, 32'h000000B2, 4'b0001);
    set_ptr(19'd414718);
    wr(8'hB0); wr(8'hB1); wr(8'hB2); do_flush();
    wait_drain("wrap");

    // Drawing rises while a request is up: held until ack, nothing new until drawing drops.
    auto_ack = 1'b0;
    expect_word(17'h00100, 32'h63626160, 4'hF);
    expect_word(17'h00101, 32'h67666564, 4'hF);
    set_ptr(19'h00400);
    for (int k = 0; k < 8; k++) wr(8'(8'h60 + k));
    wait_req("draw_mid");
    drawing = 1'b1;
    repeat (5) tick();
    chk("draw_mid_req_held", vram_wr_req, 1'b1);
    auto_ack = 1'b1;
    repeat (6) tick();
    chk("draw_mid_req_low", vram_wr_req, 1'b0);
    chk("draw_mid_one_left", sb.size(), 1);
    drawing = 1'b0;
    wait_drain("draw_mid");

    // Async reset during a request.
    auto_ack = 1'b0;
    set_ptr(19'h00500);
    for (int k = 0; k < 4; k++) wr(8'(8'h70 + k));
    wait_req("rst_mid");
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", vram_wr_req, 1'b0);
    chk("rst_mid_ready", cpu_ready, 1'b1);
    tick();
    reset_n = 1'b1;
    auto_ack = 1'b1;
    repeat (5) tick();
    chk("rst_mid_fifo_empty", vram_wr_req, 1'b0);
    chk("rst_mid_ready_after", cpu_ready, 1'b1);

    // vdp_super low discards the queued word, the partial word and the pointer.
    drawing = 1'b1;
    set_ptr(19'h00600);
    for (int k = 0; k < 6; k++) wr(8'(8'h80 + k));
    vdp_super = 1'b0; tick(); vdp_super = 1'b1;
    drawing = 1'b0;
    do_flush();
    repeat (5) tick();
    chk("super_clear_no_req", vram_wr_req, 1'b0);
    expect_word(17'h00000, 32'h000000C9, 4'b0001);
    wr(8'hC9); do_flush();
    wait_drain("super_clear_ptr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
